// File: rtl/linear_pkg.sv
// linear_pkg
//   Shared definitions for the linear layer output collector.
//   - collector_state_e : COLLECT (gathering beats) / HOLD (vector presented)
//   - LIN_* defaults    : default widths and shift used by the collector
//   - rnd_const/sat_max_val/sat_min_val : derive rounding offset and
//     saturation bounds from a shift amount / activation width; the
//     requantizer turns these into its localparams.
package linear_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } collector_state_e;

    localparam int LIN_DATA_WIDTH = 8;
    localparam int LIN_ACC_WIDTH  = 32;
    localparam int LIN_M          = 8;
    localparam int LIN_SHIFT      = 8;

    // Half an output LSB, added before the shift so that it rounds half up.
    function automatic longint rnd_const(input int shift);
        longint r;
        r = 0;
        if (shift > 0) begin
            r = longint'(64'sd1) << (shift - 1);
        end
        return r;
    endfunction

    function automatic longint sat_max_val(input int dw);
        return (longint'(64'sd1) << (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min_val(input int dw);
        return -(longint'(64'sd1) << (dw - 1));
    endfunction

endpackage

// File: rtl/requant_sat.sv
// requant_sat
//   Combinational requantizer: round half up, arithmetic shift right by
//   SHIFT, saturate to the signed DATA_WIDTH range.
//   Optional macro LINEAR_COLLECT_RELU_EN: negative results forced to 0
//   after saturation.
// Ports:
//   acc  in  ACC_WIDTH   signed accumulator
//   val  out DATA_WIDTH  signed requantized value
//   sat  out 1           value was clamped
module requant_sat
    import linear_pkg::*;
#(
    parameter int DATA_WIDTH = LIN_DATA_WIDTH,
    parameter int ACC_WIDTH  = LIN_ACC_WIDTH,
    parameter int SHIFT      = LIN_SHIFT
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] val,
    output logic                         sat
);

    // One extra bit so that adding the rounding offset cannot wrap.
    localparam logic signed [ACC_WIDTH:0] RND     = (ACC_WIDTH+1)'(rnd_const(SHIFT));
    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'(sat_max_val(DATA_WIDTH));
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(sat_min_val(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] OUT_MAX = DATA_WIDTH'(sat_max_val(DATA_WIDTH));
    localparam logic signed [DATA_WIDTH-1:0] OUT_MIN = DATA_WIDTH'(sat_min_val(DATA_WIDTH));

    logic signed [ACC_WIDTH:0] rounded;
    logic signed [ACC_WIDTH:0] shifted;

    always_comb begin
        rounded = $signed({acc[ACC_WIDTH-1], acc}) + RND;
        shifted = rounded >>> SHIFT;
        val     = shifted[DATA_WIDTH-1:0];
        sat     = 1'b0;
        if (shifted > SAT_MAX) begin
            val = OUT_MAX;
            sat = 1'b1;
        end else if (shifted < SAT_MIN) begin
            val = OUT_MIN;
            sat = 1'b1;
        end
`ifdef LINEAR_COLLECT_RELU_EN
        if (val[DATA_WIDTH-1]) begin
            val = '0;
        end
`endif
    end

endmodule

// File: rtl/linear_out_collector.sv
// linear_out_collector
//   Collects M serial accumulator beats, requantizes each into an
//   activation element, tracks the argmax of the raw accumulators and
//   presents the packed vector downstream.
//   Optional macro LINEAR_COLLECT_RELU_EN: ReLU on requantized elements
//   (argmax always uses the raw accumulator).
// Handshake: act_valid rises the cycle after the M-th beat and stays high
//   with act_out/argmax stable until a cycle with act_valid && act_ready;
//   a beat in that same cycle becomes element 0 of the next vector.
// Ports:
//   clk, rst                 clock, async active-high reset
//   in_acc/in_valid          one signed beat per in_valid cycle
//   in_done                  upstream end-of-vector pulse (short vector -> error)
//   clr_flags                clears sticky sat_flag/err_flag
//   act_out/act_valid/act_ready  packed vector and handshake
//   argmax_idx/argmax_val    index/value of largest raw accumulator
//   sat_flag/err_flag        sticky saturation / protocol error
module linear_out_collector
    import linear_pkg::*;
#(
    parameter int DATA_WIDTH = LIN_DATA_WIDTH,
    parameter int ACC_WIDTH  = LIN_ACC_WIDTH,
    parameter int M          = LIN_M,
    parameter int SHIFT      = LIN_SHIFT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic signed [ACC_WIDTH-1:0]        in_acc,
    input  logic                               in_valid,
    input  logic                               in_done,
    input  logic                               clr_flags,
    output logic [0:M-1][DATA_WIDTH-1:0]       act_out,
    output logic                               act_valid,
    input  logic                               act_ready,
    output logic [$clog2(M)-1:0]               argmax_idx,
    output logic signed [ACC_WIDTH-1:0]        argmax_val,
    output logic                               sat_flag,
    output logic                               err_flag
);

    localparam int CNT_W = $clog2(M);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(M - 1);

    collector_state_e              state_q, state_d;
    logic [CNT_W-1:0]              cnt_q, cnt_d;
    logic [0:M-1][DATA_WIDTH-1:0]  act_q, act_d;
    logic                          act_valid_q, act_valid_d;
    logic signed [ACC_WIDTH-1:0]   best_val_q, best_val_d;
    logic [CNT_W-1:0]              best_idx_q, best_idx_d;
    logic signed [ACC_WIDTH-1:0]   amax_val_q, amax_val_d;
    logic [CNT_W-1:0]              amax_idx_q, amax_idx_d;
    logic                          sat_q, sat_d;
    logic                          err_q, err_d;

    logic signed [DATA_WIDTH-1:0]  rq_val;
    logic                          rq_sat;

    requant_sat #(
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_WIDTH  (ACC_WIDTH),
        .SHIFT      (SHIFT)
    ) u_requant (
        .acc (in_acc),
        .val (rq_val),
        .sat (rq_sat)
    );

    logic accept;
    logic handshake;
    logic short_vec;
    logic drop;
    logic beat_sat;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        act_d       = act_q;
        act_valid_d = act_valid_q;
        best_val_d  = best_val_q;
        best_idx_d  = best_idx_q;
        amax_val_d  = amax_val_q;
        amax_idx_d  = amax_idx_q;
        beat_sat    = 1'b0;

        handshake = (state_q == HOLD) && act_ready;
        // In HOLD a beat is only taken when the vector leaves this cycle.
        accept    = in_valid && ((state_q == COLLECT) || act_ready);
        drop      = in_valid && (state_q == HOLD) && !act_ready;
        short_vec = (state_q == COLLECT) && in_done && (cnt_q != '0);

        if (handshake) begin
            state_d     = COLLECT;
            act_valid_d = 1'b0;
        end

        if (short_vec) begin
            // Partial vector abandoned; a coincident beat goes with it.
            cnt_d = '0;
        end else if (accept) begin
            act_d[cnt_q] = rq_val;
            beat_sat     = rq_sat;
            // Strictly greater so ties keep the lower index.
            if ((cnt_q == '0) || (in_acc > best_val_q)) begin
                best_val_d = in_acc;
                best_idx_d = cnt_q;
            end
            if (cnt_q == LAST) begin
                cnt_d       = '0;
                state_d     = HOLD;
                act_valid_d = 1'b1;
                amax_val_d  = best_val_d;
                amax_idx_d  = best_idx_d;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // Set events win over a coincident clear.
        sat_d = (sat_q && !clr_flags) || beat_sat;
        err_d = (err_q && !clr_flags) || drop || short_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= COLLECT;
            cnt_q       <= '0;
            act_q       <= '0;
            act_valid_q <= 1'b0;
            best_val_q  <= '0;
            best_idx_q  <= '0;
            amax_val_q  <= '0;
            amax_idx_q  <= '0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            act_q       <= act_d;
            act_valid_q <= act_valid_d;
            best_val_q  <= best_val_d;
            best_idx_q  <= best_idx_d;
            amax_val_q  <= amax_val_d;
            amax_idx_q  <= amax_idx_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
        end
    end

    assign act_out    = act_q;
    assign act_valid  = act_valid_q;
    assign argmax_idx = amax_idx_q;
    assign argmax_val = amax_val_q;
    assign sat_flag   = sat_q;
    assign err_flag   = err_q;

endmodule

// File: doc/linear_out_collector.md
# linear_out_collector

Consumer end of the linear layer's serial result stream. Accepts one signed accumulator result per strobe, requantizes each to activation width with rounding and saturation, and packs M results into a parallel activation vector for the next layer. Tracks the argmax of the raw accumulators. Presents the finished vector downstream over a valid/ready handshake.

## Interface
- DATA_WIDTH, 8, output activation width (signed)
- ACC_WIDTH, 32, input accumulator width (signed)
- M, 8, results per vector
- SHIFT, 8, requantization right-shift amount (0..ACC_WIDTH-1)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_acc  in  ACC_WIDTH  signed result beat
- in_valid  in  1  one-cycle strobe per result; one beat per high cycle
- in_done  in  1  upstream end-of-vector pulse
- clr_flags  in  1  synchronous clear of sticky flags
- act_out  out  [0:M-1] x DATA_WIDTH  signed packed vector
- act_valid  out  1  vector available
- act_ready  in  1  downstream accepts vector
- argmax_idx  out  $clog2(M)  index of largest raw accumulator
- argmax_val  out  ACC_WIDTH  that accumulator value
- sat_flag  out  1  sticky: any element saturated
- err_flag  out  1  sticky: overrun, extra beat, or short vector

## Operation
- States: COLLECT, HOLD. Reset -> COLLECT, cnt=0.
- COLLECT, in_valid: element cnt <= requant(in_acc); cnt++. Argmax update: first beat loads best; later beats replace only if strictly greater (ties keep lower index).
- Beat with cnt==M-1: the next cycle enters HOLD, act_valid=1, argmax_idx/argmax_val latched, cnt=0.
- HOLD: act_out/argmax outputs stable. act_valid && act_ready -> act_valid=0, state COLLECT.
- in_valid in the same cycle as the handshake: accepted as element 0 of the next vector.
- in_valid in HOLD without handshake: beat dropped; err_flag=1.
- in_done in COLLECT with 0<cnt<M: err_flag=1, cnt=0, partial data discarded, no act_valid. in_done with cnt==0 or in HOLD: ignored.
- Requant: form r = in_acc + (SHIFT>0 ? 2^(SHIFT-1) : 0) in ACC_WIDTH+1 bits; arithmetic shift right SHIFT (round half up); saturate to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1]. Any clamp sets sat_flag.
- clr_flags clears sat_flag and err_flag. A set event in the same cycle wins.

## Timing
- Reset values: act_out all 0, act_valid 0, argmax_idx 0, argmax_val 0, sat_flag 0, err_flag 0.
- Latency: final beat at cycle t -> act_valid high at t+1.
- Throughput: one beat per cycle in COLLECT. Back-to-back vectors are lossless when act_ready is held high.
- rst mid-collection: partial vector lost; all outputs return to reset values immediately.
- Sticky flags update one cycle after the causing event.

## Configuration
- LINEAR_COLLECT_RELU_EN defined: after saturation, negative elements are forced to 0.
- LINEAR_COLLECT_RELU_EN undefined: signed values pass through.
- Argmax always uses raw in_acc, regardless of the macro.

## Structure
- linear_pkg: collector state enum (COLLECT, HOLD). Rounding/saturation bounds as localparams derived from DATA_WIDTH/SHIFT.
- Sub-module requant_sat: combinational round/shift/saturate/ReLU. Outputs the value and a sat bit; instantiated once on in_acc.

## Test plan
- M=8, SHIFT=8, beats 256*k for k=0..7 -> act_out={0..7}, argmax_idx=7, argmax_val=1792, act_valid one cycle after beat 7, sat_flag=0.
- Rounding: 384 -> 2; -384 -> -1 (RELU_EN defined: 0); 383 -> 1.
- Saturation: beat 0x7FFFFFFF -> 127, sat_flag=1; beat 0x80000000 -> -128; clr_flags -> sat_flag=0.
- Ties: all beats 100 -> argmax_idx=0. Beats [5,9,9,...] -> argmax_idx=1.
- Backpressure: act_ready=0, 9th beat arrives -> dropped, err_flag=1, act_out unchanged. Beat coincident with handshake -> becomes element 0 of next vector.
- in_done after 3 beats -> err_flag=1, no act_valid. rst asserted after 4 beats -> all outputs 0; the next 8 beats produce a clean vector.
